// File: rtl/pio_out_multi_if.sv
// Register-bus bundle for pio_out_multi: word address, select, active-low write strobe, data.
// The slave drives readdata combinationally; there is no wait-state or backpressure signal.
interface pio_out_multi_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_out_multi.sv
// Multi-channel parallel output port with a scanned (multiplexed) view of one channel per slot.
// Writes land on the next clk edge, reads are zero-wait combinational; scan outputs lag by one cycle.
module pio_out_multi #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    NUM_CH      = 4,
  parameter int                    SCAN_DIV    = 50000,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  pio_out_multi_if.slave               bus,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0]        scan_data,
  output logic [NUM_CH-1:0]            scan_sel
);

  localparam int              PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]      IDX_LAST   = 3'(NUM_CH - 1);
  localparam logic [3:0]      A_CTRL     = 4'h8;
  localparam logic [3:0]      A_OUTSET   = 4'h9;
  localparam logic [3:0]      A_OUTCLR   = 4'hA;
  localparam logic [3:0]      A_STATUS   = 4'hB;

  logic [DATA_WIDTH-1:0] ch_q [NUM_CH];
  logic                  scan_en_q;
  logic                  blank_q;
  logic [2:0]            ch_sel_q;
  logic [PW-1:0]         presc_q;
  logic [2:0]            idx_q;
  logic [DATA_WIDTH-1:0] scan_data_q;
  logic [NUM_CH-1:0]     scan_sel_q;

  logic                  wr;
  logic                  wr_ctrl;
  logic                  scan_en_nxt;
  logic [DATA_WIDTH-1:0] wd;
  logic [NUM_CH-1:0]     sel_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [DATA_WIDTH-1:0] rd_ch;
  logic                  unused_wd;

  assign wr          = bus.chipselect & ~bus.write_n;
  assign wr_ctrl     = wr && (bus.address == A_CTRL);
  assign wd          = bus.writedata[DATA_WIDTH-1:0];
  assign scan_en_nxt = wr_ctrl ? bus.writedata[0] : scan_en_q;
  assign unused_wd   = ^bus.writedata[31:11];

  // Channel registers: direct writes, plus read-modify-write on the channel picked by ch_sel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= RESET_VALUE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && bus.address == 4'(i))
          ch_q[i] <= wd;
        else if (wr && bus.address == A_OUTSET && ch_sel_q == 3'(i))
          ch_q[i] <= ch_q[i] | wd;
        else if (wr && bus.address == A_OUTCLR && ch_sel_q == 3'(i))
          ch_q[i] <= ch_q[i] & ~wd;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_en_q <= 1'b0;
      blank_q   <= 1'b0;
      ch_sel_q  <= 3'd0;
    end else if (wr_ctrl) begin
      scan_en_q <= bus.writedata[0];
      blank_q   <= bus.writedata[1];
      ch_sel_q  <= bus.writedata[10:8];
    end
  end

  // Clearing scan_en zeroes the slot state on the same edge; the enabling edge itself does not
  // count, so a re-enabled scan always gets a full first slot at index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
    end else if (!scan_en_nxt) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
    end else if (scan_en_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    sel_nxt  = '0;
    data_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == 3'(i)) begin
        sel_nxt[i] = 1'b1;
        data_nxt   = ch_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_sel_q  <= '0;
      scan_data_q <= '0;
    end else if (scan_en_q && !blank_q) begin
      scan_sel_q  <= sel_nxt;
      scan_data_q <= data_nxt;
    end else begin
      scan_sel_q  <= '0;
      scan_data_q <= '0;
    end
  end

  assign scan_sel  = scan_sel_q;
  assign scan_data = scan_data_q;

  always_comb begin
    out_port = '0;
    for (int i = 0; i < NUM_CH; i++)
      out_port[i*DATA_WIDTH +: DATA_WIDTH] = blank_q ? '0 : ch_q[i];
  end

  always_comb begin
    rd_ch = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.address == 4'(i)) rd_ch = ch_q[i];
  end

  always_comb begin
    bus.readdata = '0;
    if (!bus.address[3])
      bus.readdata[DATA_WIDTH-1:0] = rd_ch;
    else if (bus.address == A_CTRL)
      bus.readdata = {21'd0, ch_sel_q, 6'd0, blank_q, scan_en_q};
    else if (bus.address == A_STATUS)
      bus.readdata = {28'd0, scan_en_q, idx_q};
  end

endmodule

// File: tb/tb_pio_out_multi.sv
// Directed bench for pio_out_multi (4 channels x 8 bits, 4-cycle scan slots).
// Inputs change on the falling edge; outputs are sampled on the falling edge or shortly after.
module tb_pio_out_multi;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] out_port;
  logic [7:0]  scan_data;
  logic [3:0]  scan_sel;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  exp_ch [4];

  pio_out_multi_if bus_if ();

  pio_out_multi #(.DATA_WIDTH(8), .NUM_CH(4), .SCAN_DIV(4), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .out_port(out_port),
    .scan_data(scan_data), .scan_sel(scan_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; the write lands on the following rising edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_if.address = a; bus_if.writedata = d; bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; bus_if.writedata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bus_if.address = a;
    #1;
    chk(tag, 64'(bus_if.readdata), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.address = '0; bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; bus_if.writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_port", 64'(out_port), 64'h0);
    chk("rst_scan_sel", 64'(scan_sel), 64'h0);
    chk("rst_scan_data", 64'(scan_data), 64'h0);
    rd_chk("rst_ctrl", 4'h8, 32'h0);
    rd_chk("rst_status", 4'hB, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Direct channel writes, ignored writes and readback
    wr(4'h0, 32'hFFFF_FF3F);
    wr(4'h2, 32'h0000_005B);
    chk("out_port_ch0_ch2", 64'(out_port), 64'h005B_003F);
    rd_chk("rd_ch2", 4'h2, 32'h0000_005B);
    rd_chk("rd_ch5", 4'h5, 32'h0);
    @(negedge clk);
    wr(4'h5, 32'hAA);
    wr(4'hB, 32'hFFFF_FFFF);
    wr(4'hD, 32'hFFFF_FFFF);
    chk("ignored_writes", 64'(out_port), 64'h005B_003F);
    rd_chk("ctrl_after_status_wr", 4'h8, 32'h0);
    rd_chk("rd_reserved", 4'hD, 32'h0);

    // ch_sel=2 via a write with junk in the unimplemented CTRL bits
    @(negedge clk);
    wr(4'h8, 32'hFFFF_FAFC);
    rd_chk("ctrl_mask", 4'h8, 32'h0000_0200);
    @(negedge clk);
    wr(4'h9, 32'h80);
    rd_chk("outset_ch2", 4'h2, 32'hDB);
    rd_chk("rd_outset_zero", 4'h9, 32'h0);
    @(negedge clk);
    wr(4'hA, 32'h0B);
    rd_chk("outclr_ch2", 4'h2, 32'hD0);
    rd_chk("ch0_kept", 4'h0, 32'h3F);
    rd_chk("ch1_kept", 4'h1, 32'h0);

    @(negedge clk);
    wr(4'h1, 32'h11);
    wr(4'h3, 32'h77);
    chk("out_port_all", 64'(out_port), 64'h77D0_113F);
    exp_ch[0] = 8'h3F; exp_ch[1] = 8'h11; exp_ch[2] = 8'hD0; exp_ch[3] = 8'h77;

    // Scan: the scan registers lag the index by one edge, each value held for 4 cycles
    wr(4'h8, 32'h1);
    bus_if.address = 4'hB;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("scan_sel_seq", 64'(scan_sel), 64'(4'b0001 << ((k / 4) % 4)));
      chk("scan_data_seq", 64'(scan_data), 64'(exp_ch[(k / 4) % 4]));
      chk("status_idx", 64'(bus_if.readdata), 64'(32'h8 | (((k + 1) / 4) % 4)));
    end

    // Blank while scanning (index 1, prescaler 0 at this point)
    wr(4'h8, 32'h3);
    chk("blank_out_port", 64'(out_port), 64'h0);
    @(negedge clk);
    chk("blank_scan_sel", 64'(scan_sel), 64'h0);
    chk("blank_scan_data", 64'(scan_data), 64'h0);
    chk("blank_out_port2", 64'(out_port), 64'h0);
    rd_chk("blank_ch2_intact", 4'h2, 32'hD0);
    wr(4'h8, 32'h1);
    chk("unblank_out_port", 64'(out_port), 64'h77D0_113F);
    @(negedge clk);
    chk("unblank_scan_sel", 64'(scan_sel), 64'b0010);
    chk("unblank_scan_data", 64'(scan_data), 64'h11);

    // Disable mid-slot at index 2, then re-enable
    @(negedge clk);
    rd_chk("status_idx2", 4'hB, 32'hA);
    wr(4'h8, 32'h0);
    rd_chk("status_disabled", 4'hB, 32'h0);
    @(negedge clk);
    chk("disabled_scan_sel", 64'(scan_sel), 64'h0);
    wr(4'h8, 32'h1);
    rd_chk("status_reenabled", 4'hB, 32'h8);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("reen_scan_sel", 64'(scan_sel), 64'b0001);
      chk("reen_scan_data", 64'(scan_data), 64'h3F);
    end
    @(negedge clk);
    chk("reen_next_slot", 64'(scan_sel), 64'b0010);

    // Asynchronous reset between edges while an OUTSET to ch_sel=1 is on the bus
    wr(4'h8, 32'h101);
    bus_if.address = 4'h9; bus_if.writedata = 32'hFF;
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_port", 64'(out_port), 64'h0);
    chk("arst_scan_sel", 64'(scan_sel), 64'h0);
    chk("arst_scan_data", 64'(scan_data), 64'h0);
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; bus_if.writedata = '0;
    @(negedge clk);
    reset = 1'b0;
    rd_chk("arst_ch1", 4'h1, 32'h0);
    rd_chk("arst_ctrl", 4'h8, 32'h0);
    @(negedge clk);
    rd_chk("arst_ch1_later", 4'h1, 32'h0);
    @(negedge clk);
    wr(4'h1, 32'h22);
    chk("post_rst_write", 64'(out_port), 64'h0000_2200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pio_out_multi.md
PIO_OUT_MULTI -- requirements
Module: pio_out_multi

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, 8, bits per channel (legal 1..32).
REQ-002 The block SHALL have parameter NUM_CH, 4, number of output channels (legal 1..8).
REQ-003 The block SHALL have parameter SCAN_DIV, 50000, clk cycles per scan slot (legal >= 2).
REQ-004 The block SHALL have parameter RESET_VALUE, 0, reset value of every channel register (DATA_WIDTH bits).
REQ-005 The block SHALL have port clk, input, 1, the single clock.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port address, input, 4, word address.
REQ-008 The block SHALL have port chipselect, input, 1, slave select.
REQ-009 The block SHALL have port write_n, input, 1, active-low write strobe.
REQ-010 The block SHALL have port writedata, input, 32, write data.
REQ-011 The block SHALL have port readdata, output, 32, read data.
REQ-012 The block SHALL have port out_port, output, NUM_CH*DATA_WIDTH, all channels in parallel, channel n at bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-013 The block SHALL have port scan_data, output, DATA_WIDTH, data of the currently scanned channel.
REQ-014 The block SHALL have port scan_sel, output, NUM_CH, one-hot select of the currently scanned channel.

Function
REQ-015 The address map SHALL be: 0x0-0x7 CH[n] read/write; 0x8 CTRL read/write; 0x9 OUTSET write-only; 0xA OUTCLR write-only; 0xB STATUS read-only; 0xC-0xF reserved.
REQ-016 A write SHALL occur on the rising clk edge where chipselect=1 and write_n=0, and SHALL use writedata[DATA_WIDTH-1:0] for channel registers.
REQ-017 A write to CH[n] with n >= NUM_CH, to STATUS, or to a reserved address SHALL be ignored.
REQ-018 CTRL SHALL hold: bit0 scan_en, bit1 blank, bits[10:8] ch_sel; all other CTRL bits SHALL read 0.
REQ-019 An OUTSET write SHALL perform CH[ch_sel] <= CH[ch_sel] | wd, and an OUTCLR write SHALL perform CH[ch_sel] <= CH[ch_sel] & ~wd; both SHALL be ignored when ch_sel >= NUM_CH.
REQ-020 readdata SHALL be combinational (zero wait states), zero-extended to 32 bits, and SHALL read 0 for OUTSET, OUTCLR, reserved addresses, and CH[n] with n >= NUM_CH.
REQ-021 STATUS SHALL return bits[2:0] as the scan index, bit3 as scan_en, and 0 in all other bits.
REQ-022 out_port SHALL equal the channel registers combinationally, and SHALL be forced to all-zero while blank=1; the channel registers SHALL be unaffected by blank.
REQ-023 The prescaler SHALL count 0..SCAN_DIV-1 while scan_en=1, and SHALL advance the index on terminal count, wrapping from NUM_CH-1 to 0.
REQ-024 While scan_en=0, the prescaler and index SHALL be held at 0.
REQ-025 scan_data and scan_sel SHALL be registered: one cycle after the index changes, or after a write to the indexed channel, they SHALL reflect the new index and data.
REQ-026 When scan_en=0 or blank=1, scan_sel and scan_data SHALL be driven to 0 on the next cycle.
REQ-027 When NUM_CH=1, the index SHALL stay 0 and scan_sel SHALL equal scan_en & ~blank, registered.
REQ-028 A write clearing scan_en mid-slot SHALL reset the prescaler and index to 0 on that edge; re-enabling SHALL start at index 0 with a full SCAN_DIV slot.

Reset
REQ-029 On reset assertion, the block SHALL asynchronously set every CH[n] to RESET_VALUE, CTRL, prescaler, index, scan_data and scan_sel to 0, so that out_port = {NUM_CH{RESET_VALUE}}.
REQ-030 After reset deassertion, the first register update SHALL occur on the next rising clk edge; reset asserted mid-operation SHALL abort any write in that cycle.

Verification (NUM_CH=4, DATA_WIDTH=8, SCAN_DIV=4, RESET_VALUE=0)
REQ-031 The bench SHALL check: reset, write CH0=0x3F and CH2=0x5B -> out_port=0x005B003F; readback CH2=0x0000005B; read CH5=0.
REQ-032 The bench SHALL check: CTRL=0x200, OUTSET 0x80 then OUTCLR 0x0B -> CH2=0xD0, and CH0 and CH1 unchanged.
REQ-033 The bench SHALL check: CTRL=0x1 -> scan_sel sequence 0001,0010,0100,1000,0001 with each value held 4 cycles; scan_data tracks CH[index]; STATUS[2:0] matches the index.
REQ-034 The bench SHALL check: CTRL=0x3 while scanning -> out_port=0, scan_sel=0, scan_data=0 next cycle; CTRL=0x1 -> outputs restore and readback is intact.
REQ-035 The bench SHALL check: clear scan_en at index 2 mid-slot, then re-enable -> index=0 and scan_sel=0001 for a full 4 cycles.
REQ-036 The bench SHALL check: assert reset asynchronously between edges during an OUTSET write -> all outputs are 0 immediately and CH[ch_sel] stays 0.
